// File: rtl/bcd_stopwatch_core.sv
// bcd_stopwatch_core
// Four-digit BCD run/hold stopwatch feeding a scanned seven-segment display.
// Two active-low push-buttons: start/stop toggles RUN/HOLD, clear returns to
// IDLE with all digits at zero. Contains key conditioning, a run/hold FSM,
// a count-rate prescaler and a cascaded BCD counter.
//
// Build option: define STOPWATCH_DEBOUNCE_EN to add per-key debounce counters
// (press event after DB_CNT stable-low cycles). Without it, every falling
// edge of the synchronized key is a press event.
module bcd_stopwatch_core #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 100,
  parameter int DB_MS    = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_n,
  input  logic       key_clr_n,
  output logic [3:0] bcd3,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic       running,
  output logic       ovf
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int DB_CNT   = CLK_FREQ / 1000 * DB_MS;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Illegal parameter sets (TICK_DIV < 2 or DB_CNT < 1) show up as this
  // named block in the elaborated hierarchy.
  if ((TICK_DIV < 2) || (DB_CNT < 1)) begin : g_illegal_params
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Increment a four-digit packed BCD value; bit 16 is the carry out of
  // the thousands digit (the 9999 -> 0000 wrap).
  function automatic logic [16:0] bcd_inc(input logic [15:0] d);
    logic [15:0] r;
    logic        c;
    r = d;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (d[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = d[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  // Bit 0 = start/stop key, bit 1 = clear key.
  logic [1:0] keys_n;
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] s_n;
  logic [1:0] ev_d;
  logic [1:0] ev_q;
  logic       ev_start;
  logic       ev_clr;

  assign keys_n = {key_clr_n, key_start_n};

  // Two-flop synchronizers for the asynchronous keys; released (1) in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= keys_n;
      sync2_q <= sync1_q;
    end
  end

  assign s_n = sync2_q;

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CNT + 1);

  logic [1:0][DBW-1:0] db_cnt_q;
  logic [1:0][DBW-1:0] db_cnt_d;
  logic [1:0]          stable_q;
  logic [1:0]          stable_d;

  // Debounce: accept a new level only after DB_CNT consecutive cycles of it;
  // an accepted high-to-low change is the press event.
  always_comb begin
    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    ev_d     = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (s_n[k] != stable_q[k]) begin
        if (db_cnt_q[k] == DBW'(DB_CNT - 1)) begin
          stable_d[k] = s_n[k];
          db_cnt_d[k] = '0;
          ev_d[k]     = ~s_n[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DBW'(1);
        end
      end else begin
        db_cnt_d[k] = '0;
      end
    end
  end

  // Debounce counter and accepted-level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      stable_q <= 2'b11;
    end else begin
      db_cnt_q <= db_cnt_d;
      stable_q <= stable_d;
    end
  end
`else
  logic [1:0] prev_q;

  // Falling edge of the synchronized key is the press event.
  always_comb begin
    ev_d = prev_q & ~s_n;
  end

  // Previous synchronized key level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 2'b11;
    end else begin
      prev_q <= s_n;
    end
  end
`endif

  // Register the one-cycle press events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q <= 2'b00;
    end else begin
      ev_q <= ev_d;
    end
  end

  assign ev_start = ev_q[0];
  assign ev_clr   = ev_q[1];

  state_t          state_q;
  state_t          state_d;
  logic            running_q;
  logic [PW-1:0]   presc_q;
  logic [PW-1:0]   presc_d;
  logic            tick;
  logic [15:0]     dig_q;
  logic [15:0]     dig_d;
  logic [16:0]     inc;
  logic            ovf_q;
  logic            ovf_d;

  // Run/hold FSM next state; clear overrides start/stop.
  always_comb begin
    state_d = state_q;
    if (ev_clr) begin
      state_d = IDLE;
    end else if (ev_start) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = HOLD;
        HOLD:    state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state and registered RUN decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
    end
  end

  assign tick = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));

  // Prescaler: counts only in RUN, frozen in IDLE/HOLD so a resume keeps
  // the partial period; zeroed on clear and on a fresh start from IDLE.
  always_comb begin
    presc_d = presc_q;
    if (ev_clr) begin
      presc_d = '0;
    end else if ((state_q == IDLE) && ev_start) begin
      presc_d = '0;
    end else if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  // Cascaded BCD counter with registered wrap pulse.
  always_comb begin
    inc   = bcd_inc(dig_q);
    dig_d = dig_q;
    ovf_d = 1'b0;
    if (ev_clr) begin
      dig_d = '0;
    end else if (tick) begin
      dig_d = inc[15:0];
      ovf_d = inc[16];
    end
  end

  // Prescaler, digit and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bcd3    = dig_q[15:12];
  assign bcd2    = dig_q[11:8];
  assign bcd1    = dig_q[7:4];
  assign bcd0    = dig_q[3:0];
  assign running = running_q;
  assign ovf     = ovf_q;

endmodule
